npc_seq: RTL and testbench

- Multi-cycle control sequencer for the NPC core.
- Fetches each instruction over a valid/ready instruction-memory port and holds it stable for the combinational decoder.
- Latches the decoder's control outputs, runs an optional data-memory access, then emits one-cycle commit strobes for the register file, CSR file and PC.
- Sits between the IFU/LSU memory ports and the decoder/EXU/WBU datapath; detects bus hangs with a timeout counter.

---
 rtl/npc_seq.sv | 149 ++++++++++++++
 tb/tb_npc_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npc_seq.sv
// Multi-cycle control sequencer for the NPC core: fetch, decode latch, optional
// data-memory access, then a single write-back cycle of commit strobes.
//
// state  | meaning
// FETCH  | instruction request outstanding on the IFU port
// WAIT_I | request accepted, waiting for instruction data
// DECODE | inst stable, decoder outputs captured
// EXEC   | route to MEM for loads/stores, else straight to WB
// MEM    | data request outstanding on the LSU port
// WAIT_D | data request accepted, waiting for response
// WB     | one-cycle commit strobes
// ERR    | bus hang detected; only rst leaves
module npc_seq #(
    parameter int TIMEOUT = 255,
    parameter int CW      = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    input  logic        ifu_resp_valid,
    input  logic [31:0] ifu_rdata,
    output logic [31:0] inst,
    input  logic        dec_wen,
    input  logic        dec_mem_valid,
    input  logic        dec_mem_wen,
    input  logic [7:0]  dec_wmask,
    input  logic        dec_csr_wen,
    input  logic        dec_is_ecall,
    input  logic        dec_is_mret,
    output logic        lsu_req_valid,
    input  logic        lsu_req_ready,
    output logic        lsu_wen,
    output logic [7:0]  lsu_wmask,
    input  logic        lsu_resp_valid,
    output logic        rf_wen,
    output logic        csr_wen,
    output logic        pc_wen,
    output logic        trap_taken,
    output logic        mret_taken,
    output logic        retire,
    output logic        bus_err,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        WAIT_I = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WAIT_D = 3'd5,
        WB     = 3'd6,
        ERR    = 3'd7
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  tmo_cnt;
    logic           timed;
    logic           tmo_hit;

    logic           l_wen;
    logic           l_mem_valid;
    logic           l_mem_wen;
    logic [7:0]     l_wmask;
    logic           l_csr_wen;
    logic           l_ecall;
    logic           l_mret;

    always_comb begin
        state_nxt     = state;
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        lsu_wen       = 1'b0;
        lsu_wmask     = 8'h00;
        rf_wen        = 1'b0;
        csr_wen       = 1'b0;
        pc_wen        = 1'b0;
        trap_taken    = 1'b0;
        mret_taken    = 1'b0;
        retire        = 1'b0;
        case (state)
            FETCH: begin
                ifu_req_valid = 1'b1;
                if (ifu_req_ready) state_nxt = WAIT_I;
            end
            WAIT_I: if (ifu_resp_valid) state_nxt = DECODE;
            DECODE: state_nxt = EXEC;
            EXEC:   state_nxt = l_mem_valid ? MEM : WB;
            MEM: begin
                lsu_req_valid = 1'b1;
                lsu_wen       = l_mem_wen;
                lsu_wmask     = l_mem_wen ? l_wmask : 8'h00;
                if (lsu_req_ready) state_nxt = WAIT_D;
            end
            WAIT_D: if (lsu_resp_valid) state_nxt = WB;
            WB: begin
                pc_wen     = 1'b1;
                retire     = 1'b1;
                rf_wen     = l_wen;
                csr_wen    = l_csr_wen;
                trap_taken = l_ecall;
                mret_taken = l_mret;
                state_nxt  = FETCH;
            end
            ERR:     state_nxt = ERR;
            default: state_nxt = ERR;
        endcase

        // The TIMEOUT-th consecutive cycle stuck in a wait state trips the error.
        timed   = (state == FETCH) || (state == WAIT_I) ||
                  (state == MEM)   || (state == WAIT_D);
        tmo_hit = timed && (state_nxt == state) && (tmo_cnt == CW'(TIMEOUT - 1));
        if (tmo_hit) state_nxt = ERR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            tmo_cnt     <= '0;
            inst        <= 32'h0;
            l_wen       <= 1'b0;
            l_mem_valid <= 1'b0;
            l_mem_wen   <= 1'b0;
            l_wmask     <= 8'h00;
            l_csr_wen   <= 1'b0;
            l_ecall     <= 1'b0;
            l_mret      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) tmo_cnt <= '0;
            else if (timed)         tmo_cnt <= tmo_cnt + 1'b1;
            if (state == WAIT_I && ifu_resp_valid) inst <= ifu_rdata;
            if (state == DECODE) begin
                l_wen       <= dec_wen;
                l_mem_valid <= dec_mem_valid;
                l_mem_wen   <= dec_mem_wen;
                l_wmask     <= dec_wmask;
                l_csr_wen   <= dec_csr_wen;
                l_ecall     <= dec_is_ecall;
                l_mret      <= dec_is_mret;
            end
        end
    end

    assign bus_err   = (state == ERR);
    assign state_dbg = state;

endmodule

// File: tb/tb_npc_seq.sv
// Self-checking bench for npc_seq: randomized instruction mix and memory
// latencies checked against a cycle-count / strobe-count reference model.
module tb_npc_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_rdata, inst;
    logic        dec_wen, dec_mem_valid, dec_mem_wen, dec_csr_wen, dec_is_ecall, dec_is_mret;
    logic [7:0]  dec_wmask;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [7:0]  lsu_wmask;
    logic        rf_wen, csr_wen, pc_wen, trap_taken, mret_taken, retire, bus_err;
    logic [2:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       mem;
        logic       store;
        logic [7:0] wmask;
        logic       rf;
        logic       csr;
        logic       trap;
        logic       mret;
    } exp_t;

    npc_seq #(.TIMEOUT(255), .CW(8)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .inst(inst),
        .dec_wen(dec_wen), .dec_mem_valid(dec_mem_valid), .dec_mem_wen(dec_mem_wen),
        .dec_wmask(dec_wmask), .dec_csr_wen(dec_csr_wen), .dec_is_ecall(dec_is_ecall),
        .dec_is_mret(dec_is_mret),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_wmask(lsu_wmask), .lsu_resp_valid(lsu_resp_valid),
        .rf_wen(rf_wen), .csr_wen(csr_wen), .pc_wen(pc_wen), .trap_taken(trap_taken),
        .mret_taken(mret_taken), .retire(retire), .bus_err(bus_err), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Minimal RV32 decoder standing in for the real combinational decoder.
    always_comb begin
        dec_wen = 1'b0; dec_mem_valid = 1'b0; dec_mem_wen = 1'b0; dec_wmask = 8'h00;
        dec_csr_wen = 1'b0; dec_is_ecall = 1'b0; dec_is_mret = 1'b0;
        case (inst[6:0])
            7'h13: dec_wen = 1'b1;
            7'h03: begin dec_wen = 1'b1; dec_mem_valid = 1'b1; end
            7'h23: begin
                dec_mem_valid = 1'b1;
                dec_mem_wen   = 1'b1;
                case (inst[14:12])
                    3'd0:    dec_wmask = 8'h01;
                    3'd1:    dec_wmask = 8'h03;
                    default: dec_wmask = 8'h0f;
                endcase
            end
            7'h73: begin
                if (inst == 32'h00000073)      dec_is_ecall = 1'b1;
                else if (inst == 32'h30200073) dec_is_mret = 1'b1;
                else if (inst[14:12] != 3'd0) begin
                    dec_csr_wen = 1'b1;
                    dec_wen     = (inst[11:7] != 5'd0);
                end
            end
            default: ;
        endcase
    end

    function automatic exp_t mk_exp(input logic mem, input logic store, input logic [7:0] wm,
                                    input logic rf, input logic csr, input logic trap,
                                    input logic mret);
        exp_t e;
        e.mem = mem; e.store = store; e.wmask = wm; e.rf = rf;
        e.csr = csr; e.trap = trap; e.mret = mret;
        return e;
    endfunction

    task automatic clear_inputs();
        ifu_req_ready = 1'b0; ifu_resp_valid = 1'b0;
        lsu_req_ready = 1'b0; lsu_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        checks++;
        if (state_dbg !== 3'd0 || inst !== 32'h0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: state=%0d inst=%h bus_err=%b, want 0/0/0", state_dbg, inst, bus_err);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({ifu_req_valid, lsu_req_valid, lsu_wen, lsu_wmask, rf_wen, csr_wen, pc_wen,
             trap_taken, mret_taken, retire, bus_err} !== {1'b1, 17'h0}) begin
            errors++;
            $display("FAIL post_reset_outputs: ifu_req=%b lsu_req=%b strobes=%b%b%b%b%b%b, want ifu_req=1 rest 0",
                     ifu_req_valid, lsu_req_valid, rf_wen, csr_wen, pc_wen, trap_taken, mret_taken, retire);
        end
    endtask

    // Acts as IFU/LSU slave with the given ready/response delays and checks
    // one instruction from FETCH through WB against the expected profile.
    task automatic run_inst(input logic [31:0] ins, input exp_t e,
                            input int ird, input int irs, input int lrd, input int lrs,
                            input string name);
        int  cycles = 0, guard = 0;
        int  n_pc = 0, n_ret = 0, n_rf = 0, n_csr = 0, n_trap = 0, n_mret = 0, n_lreq = 0;
        int  ireq_n = 0, icnt = 0, lreq_n = 0, lcnt = 0;
        bit  ipend = 0, lpend = 0, done = 0, bad_lsu = 0;
        int  exp_cycles;
        logic [7:0] exp_wm;

        exp_cycles = 5 + ird + irs + (e.mem ? 2 + lrd + lrs : 0);
        exp_wm     = e.store ? e.wmask : 8'h00;
        ifu_rdata  = ins;
        while (!done && guard < 300) begin
            guard++;
            clear_inputs();
            if (ipend) begin
                if (icnt >= irs) begin ifu_resp_valid = 1'b1; ipend = 0; end
                else icnt++;
            end
            if (ifu_req_valid) begin
                if (ireq_n >= ird) begin ifu_req_ready = 1'b1; ipend = 1; icnt = 0; end
                ireq_n++;
            end
            if (lpend) begin
                if (lcnt >= lrs) begin lsu_resp_valid = 1'b1; lpend = 0; end
                else lcnt++;
            end
            if (lsu_req_valid) begin
                if (lreq_n >= lrd) begin lsu_req_ready = 1'b1; lpend = 1; lcnt = 0; end
                lreq_n++;
            end
            cycles++;
            n_pc += int'(pc_wen);  n_ret += int'(retire); n_rf += int'(rf_wen);
            n_csr += int'(csr_wen); n_trap += int'(trap_taken); n_mret += int'(mret_taken);
            if (lsu_req_valid) begin
                n_lreq++;
                if (lsu_wen !== e.store || lsu_wmask !== exp_wm) bad_lsu = 1;
            end else if (lsu_wen !== 1'b0 || lsu_wmask !== 8'h00) bad_lsu = 1;
            if (retire === 1'b1) done = 1;
            @(negedge clk);
        end
        clear_inputs();
        checks++;
        if (!done || cycles != exp_cycles) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles (done=%0b), want %0d", name, cycles, done, exp_cycles);
        end
        checks++;
        if (n_pc != 1 || n_ret != 1) begin
            errors++;
            $display("FAIL %s pc_retire: pc_wen=%0d retire=%0d, want 1/1", name, n_pc, n_ret);
        end
        checks++;
        if (n_rf != int'(e.rf) || n_csr != int'(e.csr) || n_trap != int'(e.trap) || n_mret != int'(e.mret)) begin
            errors++;
            $display("FAIL %s strobes: rf=%0d csr=%0d trap=%0d mret=%0d, want %0d/%0d/%0d/%0d",
                     name, n_rf, n_csr, n_trap, n_mret, e.rf, e.csr, e.trap, e.mret);
        end
        checks++;
        if (n_lreq != (e.mem ? 1 + lrd : 0) || bad_lsu) begin
            errors++;
            $display("FAIL %s lsu_req: %0d cycles bad_attr=%0b, want %0d cycles wen=%b mask=%h",
                     name, n_lreq, bad_lsu, e.mem ? 1 + lrd : 0, e.store, exp_wm);
        end
        checks++;
        if (inst !== ins || state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL %s after_wb: inst=%h state=%0d, want %h/0", name, inst, state_dbg, ins);
        end
    endtask

    task automatic test_directed();
        run_inst(32'h00100093, mk_exp(0, 0, 8'h00, 1, 0, 0, 0), 0, 0, 0, 0, "addi");
        run_inst(32'h00112023, mk_exp(1, 1, 8'h0f, 0, 0, 0, 0), 0, 0, 3, 0, "sw");
        run_inst(32'h00012083, mk_exp(1, 0, 8'h00, 1, 0, 0, 0), 0, 0, 0, 0, "lw");
        run_inst(32'h00000073, mk_exp(0, 0, 8'h00, 0, 0, 1, 0), 0, 0, 0, 0, "ecall");
        run_inst(32'h30200073, mk_exp(0, 0, 8'h00, 0, 0, 0, 1), 0, 0, 0, 0, "mret");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [31:0] ins;
            exp_t        e;
            logic [4:0]  rd  = 5'($urandom_range(1, 31));
            logic [4:0]  rs1 = 5'($urandom);
            logic [11:0] imm = 12'($urandom);
            logic [2:0]  f3;
            case ($urandom_range(0, 5))
                0: begin ins = {imm, rs1, 3'b000, rd, 7'h13}; e = mk_exp(0, 0, 8'h00, 1, 0, 0, 0); end
                1: begin ins = {imm, rs1, 3'b010, rd, 7'h03}; e = mk_exp(1, 0, 8'h00, 1, 0, 0, 0); end
                2: begin
                    f3  = 3'($urandom_range(0, 2));
                    ins = {imm[11:5], rd, rs1, f3, imm[4:0], 7'h23};
                    e   = mk_exp(1, 1, (f3 == 3'd0) ? 8'h01 : (f3 == 3'd1) ? 8'h03 : 8'h0f, 0, 0, 0, 0);
                end
                3: begin ins = 32'h00000073; e = mk_exp(0, 0, 8'h00, 0, 0, 1, 0); end
                4: begin ins = 32'h30200073; e = mk_exp(0, 0, 8'h00, 0, 0, 0, 1); end
                default: begin ins = {imm, rs1, 3'b001, rd, 7'h73}; e = mk_exp(0, 0, 8'h00, 1, 1, 0, 0); end
            endcase
            run_inst(ins, e, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3), "rand");
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        int bad = 0;
        ifu_rdata = 32'h00100093;
        ifu_req_ready = 1'b1;
        @(negedge clk);
        ifu_req_ready = 1'b0;
        while (state_dbg === 3'd1 && n < 400) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 255 || state_dbg !== 3'd7 || bus_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_wait_i: %0d cycles in WAIT_I then state=%0d bus_err=%b, want 255/7/1",
                     n, state_dbg, bus_err);
        end
        for (int i = 0; i < 20; i++) begin
            {ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid} = 4'($urandom);
            @(negedge clk);
            if (bus_err !== 1'b1 || state_dbg !== 3'd7 ||
                {ifu_req_valid, lsu_req_valid, rf_wen, csr_wen, pc_wen, trap_taken, mret_taken, retire} !== 8'h0)
                bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL err_absorbing: %0d cycles left ERR or drove outputs, want 0", bad);
        end
        clear_inputs();
        test_reset();
    endtask

    task automatic test_reset_mid();
        int strobes = 0;
        ifu_rdata = 32'h00012083;
        ifu_req_ready = 1'b1;  @(negedge clk);
        clear_inputs(); ifu_resp_valid = 1'b1; @(negedge clk);
        clear_inputs(); @(negedge clk);
        @(negedge clk);
        lsu_req_ready = 1'b1; @(negedge clk);
        clear_inputs();
        checks++;
        if (state_dbg !== 3'd5) begin
            errors++;
            $display("FAIL reach_wait_d: state=%0d, want 5", state_dbg);
        end
        rst = 1'b1; @(negedge clk);
        rst = 1'b0;
        lsu_resp_valid = 1'b1; ifu_resp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            strobes += int'(rf_wen) + int'(pc_wen) + int'(retire) + int'(csr_wen) + int'(lsu_req_valid);
            if (state_dbg !== 3'd0 || inst !== 32'h0) strobes += 100;
            @(negedge clk);
        end
        clear_inputs();
        checks++;
        if (strobes != 0) begin
            errors++;
            $display("FAIL reset_mid_late_resp: score=%0d, want 0 (state=%0d inst=%h)", strobes, state_dbg, inst);
        end
        run_inst(32'h00100093, mk_exp(0, 0, 8'h00, 1, 0, 0, 0), 1, 2, 0, 0, "addi_after_rst");
    endtask

    initial begin
        rst = 1'b1;
        ifu_rdata = 32'h0;
        clear_inputs();
        test_reset();
        test_directed();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
